// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared defaults and stage-count helper for the pipelined CLA adder
//
// Purpose: default operand width / group size and the derivation of the
// pipeline depth, shared by cla_group and cla_pipe_adder.
// Ports: none (package).

package cla_pkg;

  localparam int CLA_WIDTH = 32;
  localparam int CLA_GROUP = 8;

  // Number of pipeline stages (== latency). Clamped to 1 so that a bad
  // parameter set still elaborates far enough for the top-level check to fire.
  function automatic int cla_nstg(input int width, input int group);
    if (group < 1 || width < group) return 1;
    return width / group;
  endfunction

endpackage

// File: rtl/cla_group.sv
// rtl/cla_group.sv - combinational GROUP-bit carry-lookahead block
//
// Purpose: one slice of the adder; every carry is a flat sum of products of
// the per-bit generate/propagate terms, no ripple between bit positions.
// Ports:
//   a, b  in  GROUP  slice operands
//   cin   in  1      carry into bit 0 of the slice
//   s     out GROUP  slice sum
//   cout  out 1      carry out of the slice
//   gp    out 1      group propagate (all bits propagate)
//   gg    out 1      group generate (carry out independent of cin)

module cla_group #(
  parameter int GROUP = 8
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] s,
  output logic             cout,
  output logic             gp,
  output logic             gg
);

  logic [GROUP-1:0] p;
  logic [GROUP-1:0] g;
  logic [GROUP:0]   c;

  assign p = a ^ b;
  assign g = a & b;

  // c[i+1] = g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ... | p[i..0]cin.
  // 'run' accumulates the product of propagates above the generate term
  // currently being added, so each carry is written out as its own SOP.
  always_comb begin : p_carry
    logic run;
    run = 1'b0;
    gg  = 1'b0;
    c   = '0;
    c[0] = cin;
    for (int i = 0; i < GROUP; i++) begin
      run = 1'b1;
      for (int j = i; j >= 0; j--) begin
        c[i+1] = c[i+1] | (run & g[j]);
        run    = run & p[j];
      end
      if (i == GROUP - 1) gg = c[i+1];
      c[i+1] = c[i+1] | (run & cin);
    end
  end

  assign s    = p ^ c[GROUP-1:0];
  assign cout = c[GROUP];
  assign gp   = &p;

endmodule

// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - pipelined carry-lookahead adder/subtractor with valid/ready
//
// Purpose: WIDTH-bit add/subtract resolved GROUP bits per stage; NSTG stages,
// NSTG cycles of latency, one result per cycle when not back-pressured.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid / in_ready operand handshake (in_ready = pipe may advance)
//   a, b, cin, sub      operands; sub=1 computes a-b and ignores cin
//   out_valid/out_ready result handshake
//   s, cout, ovf        sum/difference, carry out (sub: 1 = no borrow),
//                       signed overflow

module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int GROUP = CLA_GROUP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTG = cla_nstg(WIDTH, GROUP);

  if (GROUP < 1) begin : g_bad_group
    $error("cla_pipe_adder: GROUP must be at least 1");
  end else if (WIDTH % GROUP != 0) begin : g_bad_width
    $error("cla_pipe_adder: WIDTH must be a multiple of GROUP");
  end

  // Stage registers. a_q/b_q carry the operands forward so later stages can
  // find their slice; s_q collects finished slice sums from the bottom up.
  logic [NSTG-1:0][WIDTH-1:0] a_q, b_q, s_q;
  logic [NSTG-1:0]            c_q, v_q;

  // Per-stage inputs (what stage k sees this cycle) and next sum word.
  logic [NSTG-1:0][WIDTH-1:0] stg_a, stg_b, stg_s, nxt_s;
  logic [NSTG-1:0]            stg_c, stg_v;

  logic [NSTG-1:0][GROUP-1:0] grp_s;
  logic [NSTG-1:0]            grp_c, grp_p, grp_g;

  logic adv;

  // One global enable: the whole pipe moves or the whole pipe holds.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_comb begin
    stg_a = '0;
    stg_b = '0;
    stg_s = '0;
    stg_c = '0;
    stg_v = '0;
    // Subtraction is a + ~b + 1: invert b and force the carry-in.
    stg_a[0] = a;
    stg_b[0] = sub ? ~b : b;
    stg_c[0] = sub | cin;
    stg_v[0] = in_valid;
    for (int k = 1; k < NSTG; k++) begin
      stg_a[k] = a_q[k-1];
      stg_b[k] = b_q[k-1];
      stg_s[k] = s_q[k-1];
      stg_c[k] = c_q[k-1];
      stg_v[k] = v_q[k-1];
    end
  end

  for (genvar k = 0; k < NSTG; k++) begin : g_stage
    cla_group #(.GROUP(GROUP)) u_grp (
      .a    (stg_a[k][k*GROUP +: GROUP]),
      .b    (stg_b[k][k*GROUP +: GROUP]),
      .cin  (stg_c[k]),
      .s    (grp_s[k]),
      .cout (grp_c[k]),
      .gp   (grp_p[k]),
      .gg   (grp_g[k])
    );
  end

  always_comb begin
    nxt_s = stg_s;
    for (int k = 0; k < NSTG; k++) begin
      nxt_s[k][k*GROUP +: GROUP] = grp_s[k];
    end
  end

  // Data registers load only on real beats, so bubbles never overwrite the
  // last result presented at the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
      c_q <= '0;
      v_q <= '0;
    end else if (adv) begin
      for (int k = 0; k < NSTG; k++) begin
        v_q[k] <= stg_v[k];
        if (stg_v[k]) begin
          a_q[k] <= stg_a[k];
          b_q[k] <= stg_b[k];
          s_q[k] <= nxt_s[k];
          c_q[k] <= grp_c[k];
        end
      end
    end
  end

  assign out_valid = v_q[NSTG-1];
  assign s         = s_q[NSTG-1];
  assign cout      = c_q[NSTG-1];
  // Same-sign operands whose result changes sign.
  assign ovf       = (a_q[NSTG-1][WIDTH-1] == b_q[NSTG-1][WIDTH-1]) &&
                     (s_q[NSTG-1][WIDTH-1] != a_q[NSTG-1][WIDTH-1]);

  // Operand bits below a stage's slice are never read again, and the group
  // P/G outputs are reserved for a second lookahead level.
  logic unused_bits;
  assign unused_bits = ^{a_q, b_q, grp_p, grp_g};

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb/tb_cla_pipe_adder.sv - randomized scoreboard bench for cla_pipe_adder

module tb_cla_pipe_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] s;
  logic        cout;
  logic        ovf;

  cla_pipe_adder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] s;
    logic        cout;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          n_chk  = 0;
  int          n_pass = 0;
  int          cyc    = 0;
  logic        lat_chk = 1'b1;
  logic        held    = 1'b0;
  logic [31:0] held_s;
  logic        held_co;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, expv, $time);
  endtask

  // Reference: true integer arithmetic on the operands.
  function automatic exp_t model(input logic [31:0] xa, input logic [31:0] xb,
                                 input logic xc, input logic xs, input int c);
    exp_t   r;
    longint sr;
    longint ut;
    if (xs) begin
      sr     = longint'($signed(xa)) - longint'($signed(xb));
      r.s    = xa - xb;
      r.cout = (xa >= xb);
    end else begin
      sr     = longint'($signed(xa)) + longint'($signed(xb)) + longint'(xc);
      ut     = longint'(xa) + longint'(xb) + longint'(xc);
      r.s    = ut[31:0];
      r.cout = ut[32];
    end
    r.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    r.cyc = c;
    return r;
  endfunction

  task automatic pick(output logic [31:0] xa, output logic [31:0] xb,
                      output logic xc, output logic xs);
    case ($urandom_range(0, 5))
      0: begin xa = '1;           xb = 32'($urandom_range(0, 1)); end
      1: begin xa = 32'h7FFF_FFFF; xb = $urandom; end
      2: begin xa = $urandom;     xb = xa; end
      default: begin xa = $urandom; xb = $urandom; end
    endcase
    xc = 1'($urandom_range(0, 1));
    xs = ($urandom_range(0, 3) == 0);
  endtask

  // Monitor: sampled on the falling edge, mid-cycle, where every handshake
  // decision for the coming rising edge is already settled.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      held = 1'b0;
    end else begin
      if (out_valid && !out_ready) begin
        check("stall_in_ready", 64'(in_ready), 64'(0));
        if (held) begin
          check("stall_s", 64'(s), 64'(held_s));
          check("stall_cout", 64'(cout), 64'(held_co));
        end
        held    = 1'b1;
        held_s  = s;
        held_co = cout;
      end else begin
        held = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("stray_beat", 64'(out_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("sb_s", 64'(s), 64'(e.s));
          check("sb_cout", 64'(cout), 64'(e.cout));
          check("sb_ovf", 64'(ovf), 64'(e.ovf));
          if (lat_chk) check("latency", 64'(cyc - e.cyc), 64'(4));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub, cyc));
    end
  end

  task automatic direct(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                        input logic xc, input logic xs,
                        input logic [31:0] es, input logic ec, input logic eo);
    @(posedge clk); #1;
    a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 12 && !out_valid; k++) @(negedge clk);
    check({tag, "_valid"}, 64'(out_valid), 64'(1));
    check({tag, "_s"}, 64'(s), 64'(es));
    check({tag, "_cout"}, 64'(cout), 64'(ec));
    check({tag, "_ovf"}, 64'(ovf), 64'(eo));
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) begin
      @(negedge clk); #1;
    end
    check("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic stream(input int n, input int st, input int len);
    int          sent;
    int          j;
    logic [31:0] ra, rb;
    logic        rc, rs;
    sent = 0;
    j    = 0;
    pick(ra, rb, rc, rs);
    while (sent < n && j < n + 100) begin
      @(posedge clk); #1;
      out_ready = !(j >= st && j < st + len);
      in_valid  = 1'b1;
      a = ra; b = rb; cin = rc; sub = rs;
      @(negedge clk);
      if (in_ready) begin
        sent++;
        pick(ra, rb, rc, rs);
      end
      j++;
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_sent", 64'(sent), 64'(n));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #3;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_s", 64'(s), 64'(0));
    check("rst_cout", 64'(cout), 64'(0));
    check("rst_ovf", 64'(ovf), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));

    direct("add",     32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 1'b0);
    direct("ripple",  32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    direct("sub_neg", 32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    direct("sub_ovf", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
    drain();

    stream(100, 1000, 0);
    drain();

    lat_chk = 1'b0;
    stream(30, 10, 5);
    drain();
    lat_chk = 1'b1;

    // Reset with three beats in flight.
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pick(a, b, cin, sub);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_s", 64'(s), 64'(0));
    check("midrst_cout", 64'(cout), 64'(0));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("flush_quiet", 64'(out_valid), 64'(0));
    end
    @(posedge clk); #1;
    pick(a, b, cin, sub);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    stream(20, 1000, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor; successor to the fixed 8-bit CLA.
- Operand is split into GROUP-bit slices. Each pipeline stage resolves one slice with a combinational CLA group and registers its carry forward to the next stage.
- Valid/ready handshake on input and output, so it drops into streaming datapaths (ALU, accumulator, DSP chains) at full throughput.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of GROUP.
- GROUP, 8, bits resolved per pipeline stage (CLA group size).
- NSTG, WIDTH/GROUP (derived, localparam), number of pipeline stages, which equals latency in cycles.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat present
- in_ready  out  1  block can accept a beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in; ignored when sub=1
- sub  in  1  0: a+b+cin; 1: a-b (a + ~b + 1)
- out_valid  out  1  result beat present
- out_ready  in  1  downstream accepts result
- s  out  WIDTH  sum/difference
- cout  out  1  carry out of MSB; for sub, 1 means no borrow
- ovf  out  1  signed two's-complement overflow

Behaviour:
- Reset: async assert on rst_n low. All stage valids clear; out_valid=0, s=0, cout=0, ovf=0. in_ready=1 once rst_n is high.
- Advance: adv = !out_valid | out_ready.
  - in_ready = adv (combinational).
  - All stages shift together when adv=1; the whole pipe holds when adv=0.
- Accept: a beat is accepted when in_valid & in_ready.
  - Stage 0 captures b_eff = sub ? ~b : b and c0 = sub ? 1 : cin.
  - Stage 0 computes slice 0 using a[GROUP-1:0] and b_eff[GROUP-1:0].
- Stage k (k=0..NSTG-1):
  - Computes slice k from its registered operand slice and the carry registered from stage k-1.
  - Registers the slice sum, the carry out, the not-yet-consumed upper operand bits, the already-finished lower sum bits, and a valid bit.
  - Bubbles (valid=0) propagate as bubbles; their data is don't-care, but outputs hold their last value when out_valid=0.
- Latency: exactly NSTG cycles from accept to out_valid with no stall (4 for defaults).
- Throughput: one result per cycle while out_ready=1.
- Outputs:
  - s = concatenation of all slice sums, modulo 2^WIDTH.
  - cout = carry out of the final slice.
  - ovf = carry into MSB XOR carry out of MSB, i.e. (a[W-1]==b_eff[W-1]) & (s[W-1]!=a[W-1]).
- Stall: out_valid=1 & out_ready=0 freezes every stage register, and s/cout/ovf stay stable. No beat is lost or duplicated.
- Simultaneous in_valid with a stall: in_ready=0, the input is not taken, and upstream must hold it.
- Bubble-fill while stalled is not performed: the global-enable scheme is simple and accepted.
- Wrap-around: full carry ripple is required, e.g. all-ones + 1 must propagate through every stage.
- Reset mid-operation flushes all in-flight beats; none emerge after reset release.
- Out-of-range parameters: elaboration-time check fails if WIDTH % GROUP != 0 or GROUP < 1.

Decomposition:
- Shared package cla_pkg: default WIDTH/GROUP constants and a function returning NSTG.
- Sub-module cla_group: purely combinational GROUP-bit carry-lookahead block.
  - Inputs a, b, cin; outputs s, cout, plus group P/G for future multi-level use.
  - Generate/propagate terms per bit, carries computed as lookahead sums of products.
  - Instantiated once per stage inside a generate loop.
- The top level holds only the pipeline registers, the handshake and the ovf logic.

Test Plan:
- Basic add: a=0x0000_0005, b=0x0000_0003, cin=0, sub=0 -> after 4 cycles out_valid=1, s=0x0000_0008, cout=0, ovf=0.
- Full carry ripple: a=0xFFFF_FFFF, b=0x0000_0000, cin=1 -> s=0x0000_0000, cout=1, ovf=0.
- Subtract / signed overflow:
  - a=0x0000_0003, b=0x0000_0005, sub=1 -> s=0xFFFF_FFFE, cout=0.
  - a=0x7FFF_FFFF, b=0xFFFF_FFFF, sub=1 -> s=0x8000_0000, ovf=1.
- Back-to-back streaming: 100 random beats with in_valid=1 every cycle and out_ready=1 -> results match a scoreboard in order, one per cycle after the 4-cycle fill.
- Backpressure: out_ready held 0 for 5 cycles mid-stream -> in_ready=0 during the hold, s stable, no drops or duplicates, order preserved after release.
- Reset mid-flight: assert rst_n=0 with 3 beats in flight -> out_valid=0 and s=0 immediately; no stale beat appears after release; the next accepted beat emerges 4 cycles later and is correct.
